// File: rtl/ecg_class_vote.sv
// ecg_class_vote: sliding-window majority vote and alarm over per-beat ECG classes.
// Define ECG_VOTE_HIST_EN to expose the live per-class counters on class_hist.
module ecg_class_vote #(
  parameter int WIN_LEN  = 8,
  parameter int ALARM_TH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  class_in,
  input  logic        class_in_val,
  input  logic        clear,
  output logic        busy,
  output logic [2:0]  vote_class,
  output logic        vote_val,
  output logic        alarm,
  output logic [15:0] beat_cnt,
`ifdef ECG_VOTE_HIST_EN
  output logic [19:0] class_hist,
`else
`endif
  output logic        err
);
  localparam int PW = $clog2(WIN_LEN);
  localparam int FW = $clog2(WIN_LEN + 1);
  typedef enum logic [1:0] {IDLE, UPD, VOTE} state_t;
  state_t        state_q, state_d;
  logic [2:0]    win_q [WIN_LEN];
  logic [2:0]    win_d [WIN_LEN];
  logic [3:0]    cnt_q [5];
  logic [3:0]    cnt_d [5];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [2:0]    cls_q, cls_d, vote_class_q, vote_class_d;
  logic          alarm_q, alarm_d, err_q, err_d, full;
  logic [15:0]   beat_cnt_q, beat_cnt_d;
  logic [4:0]    ab_sum;
  logic [3:0]    best;
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    cls_d        = cls_q;
    vote_class_d = vote_class_q;
    alarm_d      = alarm_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    ab_sum       = '0;
    best         = '0;
    full         = fill_q == FW'(WIN_LEN);
    if (class_in_val) begin
      if (state_q != IDLE || class_in > 3'd4) err_d = 1'b1;
      else begin
        state_d = UPD;
        cls_d   = class_in;
      end
    end
    if (state_q == UPD) begin
      // When full, the entry being overwritten leaves the window in the same cycle
      for (int k = 0; k < 5; k++)
        cnt_d[k] = cnt_q[k] + 4'(cls_q == 3'(k)) - 4'(full && win_q[ptr_q] == 3'(k));
      win_d[ptr_q] = cls_q;
      ptr_d        = ptr_q == PW'(WIN_LEN - 1) ? '0 : ptr_q + 1'b1;
      fill_d       = full ? fill_q : fill_q + 1'b1;
      beat_cnt_d   = &beat_cnt_q ? beat_cnt_q : beat_cnt_q + 16'd1;
      vote_class_d = '0;
      best         = cnt_d[0];
      for (int k = 1; k < 5; k++)
        if (cnt_d[k] > best) begin
          best         = cnt_d[k];
          vote_class_d = 3'(k);
        end
      ab_sum  = 5'(cnt_d[1]) + 5'(cnt_d[2]) + 5'(cnt_d[3]) + 5'(cnt_d[4]);
      alarm_d = ab_sum >= 5'(ALARM_TH);
      state_d = VOTE;
    end
    if (state_q == VOTE) state_d = IDLE;
    if (clear) begin
      state_d      = IDLE;
      win_d        = '{default: '0};
      cnt_d        = '{default: '0};
      ptr_d        = '0;
      fill_d       = '0;
      vote_class_d = '0;
      alarm_d      = 1'b0;
      beat_cnt_d   = beat_cnt_q;
      err_d        = err_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_q        <= '{default: '0};
      cnt_q        <= '{default: '0};
      ptr_q        <= '0;
      fill_q       <= '0;
      cls_q        <= '0;
      vote_class_q <= '0;
      alarm_q      <= 1'b0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      cls_q        <= cls_d;
      vote_class_q <= vote_class_d;
      alarm_q      <= alarm_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign vote_val   = state_q == VOTE;
  assign vote_class = vote_class_q;
  assign alarm      = alarm_q;
  assign beat_cnt   = beat_cnt_q;
  assign err        = err_q;
`ifdef ECG_VOTE_HIST_EN
  assign class_hist = {cnt_q[4], cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule
